// File: rtl/fetch_decode_pkg.sv
// Shared constants, decoded-field payload and field extraction for the fetch/decode slice.
package fetch_decode_pkg;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h8002_0000;

    localparam int unsigned INSN_W   = 32;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned FUNC_W   = 6;
    localparam int unsigned IMM_W    = 26;
    localparam int unsigned IMM16_W  = 16;

    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned RS_LSB     = 21;
    localparam int unsigned RT_LSB     = 16;
    localparam int unsigned RD_LSB     = 11;
    localparam int unsigned SA_LSB     = 6;
    localparam int unsigned FUNC_LSB   = 0;
    localparam int unsigned IMM_LSB    = 0;

    localparam logic [OPCODE_W-1:0] OP_J   = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_JAL = 6'h03;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [REG_W-1:0]    rs;
        logic [REG_W-1:0]    rt;
        logic [REG_W-1:0]    rd;
        logic [REG_W-1:0]    sa;
        logic [FUNC_W-1:0]   func;
        logic [IMM_W-1:0]    imm;
    } decoded_t;

    // Every field is extracted regardless of format; imm depends on J/JAL.
    function automatic decoded_t decode_insn(input logic [INSN_W-1:0] insn);
        decoded_t d;
        d.opcode = insn[OPCODE_LSB +: OPCODE_W];
        d.rs     = insn[RS_LSB +: REG_W];
        d.rt     = insn[RT_LSB +: REG_W];
        d.rd     = insn[RD_LSB +: REG_W];
        d.sa     = insn[SA_LSB +: REG_W];
        d.func   = insn[FUNC_LSB +: FUNC_W];
        if (d.opcode == OP_J || d.opcode == OP_JAL) begin
            d.imm = insn[IMM_LSB +: IMM_W];
        end else begin
            d.imm = {{(IMM_W-IMM16_W){insn[IMM16_W-1]}}, insn[IMM_LSB +: IMM16_W]};
        end
        return d;
    endfunction

endpackage

// File: rtl/instr_mem.sv
// Word-wide instruction memory: one synchronous write port, one synchronous read port.
module instr_mem
    import fetch_decode_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1048576,
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        we,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata,
    input  logic        re,
    input  logic [31:0] raddr,
    output logic [31:0] rdata
);

    localparam int unsigned WORDS = MEM_BYTES / 4;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [31:0]      mem [WORDS];
    logic [31:0]      woff;
    logic [31:0]      roff;
    logic             w_hit;
    logic             r_hit;
    logic [IDX_W-1:0] widx;
    logic [IDX_W-1:0] ridx;
    logic             unused_bits;

    // Unsigned offset makes addresses below the base wrap to huge values, so one compare covers both ends.
    assign woff  = waddr - BASE_ADDR;
    assign roff  = raddr - BASE_ADDR;
    assign w_hit = woff < 32'(MEM_BYTES);
    assign r_hit = roff < 32'(MEM_BYTES);
    assign widx  = woff[IDX_W+1:2];
    assign ridx  = roff[IDX_W+1:2];
    assign unused_bits = ^{woff[1:0], roff[1:0]};

    always_ff @(posedge clock) begin
        if (we && w_hit) begin
            mem[widx] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= r_hit ? mem[ridx] : '0;
        end
    end

endmodule

// File: rtl/fetch_decode_top.sv
// Sequential instruction fetch from a loadable memory followed by a registered decode stage.
module fetch_decode_top
    import fetch_decode_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1048576,
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                load_en,
    input  logic [31:0]         load_addr,
    input  logic [31:0]         load_data,
    input  logic                run,
    input  logic                stall,
    output logic                valid,
    output logic [31:0]         pc_out,
    output logic [OPCODE_W-1:0] opcode_out,
    output logic [REG_W-1:0]    rs_out,
    output logic [REG_W-1:0]    rt_out,
    output logic [REG_W-1:0]    rd_out,
    output logic [REG_W-1:0]    sa_out,
    output logic [FUNC_W-1:0]   func_out,
    output logic [IMM_W-1:0]    imm_out
);

    logic [31:0] pc;
    logic [31:0] tag_pc;
    logic        tag_valid;
    logic [31:0] insn;
    logic        fetch;
    decoded_t    dec;

    // A load cycle or a stall suppresses the fetch, which also freezes the read data.
    assign fetch = run & ~stall & ~load_en;
    assign dec   = decode_insn(insn);

    instr_mem #(
        .MEM_BYTES (MEM_BYTES),
        .BASE_ADDR (BASE_ADDR)
    ) u_mem (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (load_en),
        .waddr   (load_addr),
        .wdata   (load_data),
        .re      (fetch),
        .raddr   (pc),
        .rdata   (insn)
    );

    // Fetch stage tags the read with its PC; decode stage registers fields only for real fetches.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc         <= BASE_ADDR;
            tag_pc     <= '0;
            tag_valid  <= 1'b0;
            valid      <= 1'b0;
            pc_out     <= '0;
            opcode_out <= '0;
            rs_out     <= '0;
            rt_out     <= '0;
            rd_out     <= '0;
            sa_out     <= '0;
            func_out   <= '0;
            imm_out    <= '0;
        end else if (!stall) begin
            if (fetch) begin
                pc     <= pc + 32'd4;
                tag_pc <= pc;
            end
            tag_valid <= fetch;
            valid     <= tag_valid;
            if (tag_valid) begin
                pc_out     <= tag_pc;
                opcode_out <= dec.opcode;
                rs_out     <= dec.rs;
                rt_out     <= dec.rt;
                rd_out     <= dec.rd;
                sa_out     <= dec.sa;
                func_out   <= dec.func;
                imm_out    <= dec.imm;
            end
        end
    end

endmodule

// File: tb/tb_fetch_decode_top.sv
// Directed bench for fetch_decode_top using a small memory so fetches past the end read zero.
module tb_fetch_decode_top;

    localparam logic [31:0] BASE      = 32'h8002_0000;
    localparam int unsigned MEM_BYTES = 32;

    typedef struct packed {
        logic [31:0] word;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sa;
        logic [5:0]  fn;
        logic [25:0] imm;
    } vec_t;

    logic        clock;
    logic        reset_n;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        run;
    logic        stall;
    logic        valid;
    logic [31:0] pc_out;
    logic [5:0]  opcode_out;
    logic [4:0]  rs_out;
    logic [4:0]  rt_out;
    logic [4:0]  rd_out;
    logic [4:0]  sa_out;
    logic [5:0]  func_out;
    logic [25:0] imm_out;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs [9];

    fetch_decode_top #(
        .MEM_BYTES (MEM_BYTES),
        .BASE_ADDR (BASE)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .run        (run),
        .stall      (stall),
        .valid      (valid),
        .pc_out     (pc_out),
        .opcode_out (opcode_out),
        .rs_out     (rs_out),
        .rt_out     (rt_out),
        .rd_out     (rd_out),
        .sa_out     (sa_out),
        .func_out   (func_out),
        .imm_out    (imm_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic check_word(input string tag, input int i);
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_pc"}, pc_out, BASE + 32'(i * 4));
        check({tag, "_op"}, 32'(opcode_out), 32'(vecs[i].op));
        check({tag, "_rs"}, 32'(rs_out), 32'(vecs[i].rs));
        check({tag, "_rt"}, 32'(rt_out), 32'(vecs[i].rt));
        check({tag, "_rd"}, 32'(rd_out), 32'(vecs[i].rd));
        check({tag, "_sa"}, 32'(sa_out), 32'(vecs[i].sa));
        check({tag, "_func"}, 32'(func_out), 32'(vecs[i].fn));
        check({tag, "_imm"}, 32'(imm_out), 32'(vecs[i].imm));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // word, opcode, rs, rt, rd, sa, func, imm (hand decoded)
        vecs[0] = '{32'h27BD_FFE8, 6'h09, 5'd29, 5'd29, 5'd31, 5'd31, 6'h28, 26'h3FF_FFE8};
        vecs[1] = '{32'h0085_1021, 6'h00, 5'd4,  5'd5,  5'd2,  5'd0,  6'h21, 26'h000_1021};
        vecs[2] = '{32'h0C00_8010, 6'h03, 5'd0,  5'd0,  5'd16, 5'd0,  6'h10, 26'h000_8010};
        vecs[3] = '{32'h0800_0040, 6'h02, 5'd0,  5'd0,  5'd0,  5'd1,  6'h00, 26'h000_0040};
        vecs[4] = '{32'h2402_8000, 6'h09, 5'd0,  5'd2,  5'd16, 5'd0,  6'h00, 26'h3FF_8000};
        vecs[5] = '{32'h1234_5678, 6'h04, 5'd17, 5'd20, 5'd10, 5'd25, 6'h38, 26'h000_5678};
        vecs[6] = '{32'h8C00_FFFF, 6'h23, 5'd0,  5'd0,  5'd31, 5'd31, 6'h3F, 26'h3FF_FFFF};
        vecs[7] = '{32'h0A00_8000, 6'h02, 5'd16, 5'd0,  5'd16, 5'd0,  6'h00, 26'h200_8000};
        vecs[8] = '{32'h0000_0000, 6'h00, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 26'h000_0000};

        reset_n   = 1'b0;
        run       = 1'b0;
        stall     = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;

        #3;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_pc", pc_out, 32'd0);
        check("rst_op", 32'(opcode_out), 32'd0);
        check("rst_rs", 32'(rs_out), 32'd0);
        check("rst_func", 32'(func_out), 32'd0);
        check("rst_imm", 32'(imm_out), 32'd0);

        tick();
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("idle_valid", 32'(valid), 32'd0);
        end

        for (int i = 0; i < 8; i++) begin
            load_word(BASE + 32'(i * 4), vecs[i].word);
        end
        // Out-of-range loads alias onto words 0 and 7 if the range check is broken.
        load_word(BASE + 32'h20, 32'hFFFF_FFFF);
        load_word(BASE - 32'd4, 32'hFFFF_FFFF);
        check("load_valid", 32'(valid), 32'd0);

        run = 1'b1;
        tick();
        check("lat1_valid", 32'(valid), 32'd0);
        tick();
        check_word("w0", 0);
        tick();
        check_word("w1", 1);
        tick();
        check_word("w2", 2);

        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("stall_valid", 32'(valid), 32'd1);
            check("stall_pc", pc_out, BASE + 32'h8);
            check("stall_op", 32'(opcode_out), 32'h03);
            check("stall_imm", 32'(imm_out), 32'h0008010);
        end
        stall = 1'b0;

        for (int i = 3; i < 9; i++) begin
            tick();
            check_word($sformatf("w%0d", i), i);
        end

        run = 1'b0;
        tick();
        check("drain_valid", 32'(valid), 32'd1);
        check("drain_pc", pc_out, BASE + 32'h24);
        tick();
        check("stop_valid", 32'(valid), 32'd0);
        check("stop_pc_hold", pc_out, BASE + 32'h24);

        run = 1'b1;
        tick();
        tick();
        tick();
        check("pre_rst_valid", 32'(valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_pc", pc_out, 32'd0);
        check("mid_rst_op", 32'(opcode_out), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        check("rrun_lat_valid", 32'(valid), 32'd0);
        tick();
        check_word("rw0", 0);
        tick();
        check_word("rw1", 1);

        load_word(BASE + 32'h1C, vecs[7].word);
        check_word("lw2", 2);
        tick();
        check("load_bubble_valid", 32'(valid), 32'd0);
        tick();
        check_word("lw3", 3);

        run = 1'b0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_decode_top.md
FETCH_DECODE_TOP -- requirements
Module: fetch_decode_top

Interface
REQ-001 Parameter MEM_BYTES, default 1048576, instruction-memory size in bytes (multiple of 4).
REQ-002 Parameter BASE_ADDR, default 32'h8002_0000, byte address of memory byte 0 and the reset PC.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clock  in  1  rising-edge clock for all state.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 load_en  in  1  write one word into memory this cycle.
REQ-007 load_addr  in  32  byte address of the load word; bits [1:0] ignored.
REQ-008 load_data  in  32  word to store, big-endian (bits [31:24] at the lowest byte address).
REQ-009 run  in  1  enable sequential fetch.
REQ-010 stall  in  1  freeze the whole pipeline.
REQ-011 valid  out  1  decoded outputs describe a fetched instruction.
REQ-012 pc_out  out  32  address of the decoded instruction.
REQ-013 opcode_out  out  6, rs_out  out  5, rt_out  out  5, rd_out  out  5, sa_out  out  5, func_out  out  6: decoded instruction fields.
REQ-014 imm_out  out  26  immediate or jump target field.

Function
REQ-015 Memory writes are synchronous; the word at offset (load_addr - BASE_ADDR) is written at the clock edge while load_en=1.
REQ-016 Loads outside [BASE_ADDR, BASE_ADDR+MEM_BYTES) are ignored; reads there return 32'h0.
REQ-017 Memory reads are synchronous: the address presented in cycle N yields the instruction word in cycle N+1.
REQ-018 The fetch PC advances by 4 each cycle when run=1, stall=0 and load_en=0; otherwise it holds.
REQ-019 load_en takes priority over run: no fetch is issued in a load cycle.
REQ-020 Each fetch carries its PC through the pipeline; decoded outputs appear 2 cycles after the PC is presented.
REQ-021 valid rises 2 cycles after the first fetch; it falls 2 cycles after fetching stops, one cycle per missing fetch.
REQ-022 Outputs are registered:
- opcode = insn[31:26], rs = [25:21], rt = [20:16], rd = [15:11], sa = [10:6], func = [5:0]
- all fields are output regardless of instruction format.
REQ-023 imm_out = insn[25:0] when the opcode is 6'h02 (J) or 6'h03 (JAL); otherwise insn[15:0] sign-extended to 26 bits.
REQ-024 While stall=1, the PC, the in-flight instruction and pc tag, the decoded outputs and valid all hold. Resuming continues with no skipped or duplicated instruction.
REQ-025 PC wraps modulo 2^32; there is no end-of-program detection.

Reset
REQ-026 Asserting reset_n=0 at any time, including mid-run, immediately sets:
- PC = BASE_ADDR
- valid = 0
- all decoded outputs and the pipeline registers = 0.
REQ-027 Memory contents are not affected by reset.
REQ-028 After release, the first fetch is at BASE_ADDR on the first cycle with run=1.

Structure
REQ-029 A shared package fetch_decode_pkg holds:
- BASE_ADDR default
- opcode constants OP_J=6'h02, OP_JAL=6'h03
- field bit-position constants.
REQ-030 The memory array is one sub-module, instr_mem (one synchronous write port, one synchronous read port). Fetch and decode are implemented in the top.

Verification
REQ-031 Reset and idle: reset_n=0 -> valid=0, all outputs 0. Release with run=0 -> valid stays 0 for 10 cycles.
REQ-032 Load 32'h27BDFFE8 at 32'h80020000, then run=1 -> 2 cycles later:
- valid=1, pc_out=32'h80020000
- opcode=001001, rs=11101, rt=11101, imm=26'h3FFFFE8, func=101000.
REQ-033 Load 32'h00851021 at 32'h80020004 -> next decode:
- pc_out=32'h80020004
- opcode=0, rs=4, rt=5, rd=2, sa=0, func=6'h21.
REQ-034 Load 32'h0C008010 (JAL) -> opcode=6'h03, imm_out=26'h0008010.
REQ-035 stall=1 for 3 cycles mid-run -> pc_out and fields frozen; after release the PCs continue +4 with no gap or repeat.
REQ-036 Fetch beyond the loaded region -> word 0 decoded (all fields 0). reset_n pulsed mid-run -> valid=0 at once, and fetch restarts at 32'h80020000 with memory intact.
